// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one single-port synchronous word memory between the I (fetch) and D (load/store) ports
// Ports: clk, rst_n (async active-low); I port i_req/i_addr -> i_gnt/i_rvalid/i_rdata;
// D port d_req/d_we/d_addr/d_wdata -> d_gnt/d_rvalid/d_rdata; memory side mem_en/mem_we/mem_addr/mem_wdata <- mem_rdata;
// i_wait_cnt exposes the I starvation count. Define ARB_STARVE_GUARD_EN to let a starved I port win over D.
module mips_mem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        i_wait_cnt
);
  typedef enum logic [1:0] {TAG_NONE, TAG_I, TAG_D} tag_e;
  tag_e              tag_q, tag_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic [2:0]        wait_q, wait_d;
  logic              force_i;
  always_comb begin
`ifdef ARB_STARVE_GUARD_EN
    force_i = i_req && (wait_q >= 3'(MAX_WAIT));
`else
    force_i = 1'b0;
`endif
    // grants are blanked while reset is asserted so nothing reaches memory
    d_gnt     = rst_n && d_req && !force_i;
    i_gnt     = rst_n && i_req && !d_gnt;
    mem_en    = i_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = i_gnt ? i_addr : d_gnt ? d_addr : '0;
    mem_wdata = d_gnt ? d_wdata : '0;
    tag_d     = i_gnt ? TAG_I : (d_gnt && !d_we) ? TAG_D : TAG_NONE;
    wait_d    = (i_req && !i_gnt) ? ((wait_q >= 3'(MAX_WAIT)) ? wait_q : wait_q + 3'd1) : 3'd0;
    i_rvalid  = tag_q == TAG_I;
    d_rvalid  = tag_q == TAG_D;
    // returning data passes straight through; the register only holds it afterwards
    i_rdata_d = i_rvalid ? mem_rdata : i_rdata_q;
    d_rdata_d = d_rvalid ? mem_rdata : d_rdata_q;
    i_rdata   = i_rdata_d;
    d_rdata   = d_rdata_d;
    i_wait_cnt = wait_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q     <= TAG_NONE;
      wait_q    <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      tag_q     <= tag_d;
      wait_q    <= wait_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter: randomized and directed checks of mips_mem_arbiter against a behavioural model
module tb_mips_mem_arbiter;
  localparam int MAX_WAIT = 4;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we;
  logic [9:0]  i_addr, d_addr, mem_addr;
  logic [31:0] d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic        i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_we;
  logic [2:0]  i_wait_cnt;
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  int          n_cmp = 0, n_err = 0;
  int          m_tag = 0, m_wait = 0;
  logic [31:0] m_data = '0, m_ilast = '0, m_dlast = '0;
  logic        lw_i = 1'b0, lw_d = 1'b0;

  mips_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .i_wait_cnt(i_wait_cnt)
  );

  always #5 clk = ~clk;

  initial mem_rdata = '0;
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    logic ew_i, ew_d, force_i;
    @(negedge clk);
    if (!rst_n) begin
      m_tag = 0; m_wait = 0; m_ilast = '0; m_dlast = '0;
    end
    if (m_tag == 1) m_ilast = m_data;
    if (m_tag == 2) m_dlast = m_data;
    force_i = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    force_i = i_req && m_wait == MAX_WAIT;
`endif
    ew_d = rst_n && d_req && !force_i;
    ew_i = rst_n && i_req && !ew_d;
    chk("i_gnt", 32'(i_gnt), 32'(ew_i));
    chk("d_gnt", 32'(d_gnt), 32'(ew_d));
    chk("mem_en", 32'(mem_en), 32'(ew_i || ew_d));
    chk("mem_we", 32'(mem_we), 32'(ew_d && d_we));
    chk("mem_addr", 32'(mem_addr), ew_i ? 32'(i_addr) : ew_d ? 32'(d_addr) : 32'd0);
    if ((ew_d && d_we) || !rst_n) chk("mem_wdata", mem_wdata, rst_n ? d_wdata : 32'd0);
    chk("i_rvalid", 32'(i_rvalid), 32'(m_tag == 1));
    chk("d_rvalid", 32'(d_rvalid), 32'(m_tag == 2));
    chk("i_rdata", i_rdata, m_ilast);
    chk("d_rdata", d_rdata, m_dlast);
    chk("i_wait_cnt", 32'(i_wait_cnt), 32'(m_wait));
    m_tag  = ew_i ? 1 : (ew_d && !d_we) ? 2 : 0;
    m_data = ew_i ? ref_mem[i_addr] : ref_mem[d_addr];
    if (ew_d && d_we) ref_mem[d_addr] = d_wdata;
    m_wait = (rst_n && i_req && !ew_i) ? ((m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1) : 0;
    lw_i = ew_i;
    lw_d = ew_d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 1024; i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[5] = 32'h2842000A;
    ref_mem[5] = 32'h2842000A;
    rst_n = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    i_addr = 10'd1; d_addr = 10'd2; d_wdata = '0;
    repeat (3) cycle();
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_gnt", 32'({i_gnt, d_gnt}), 32'd0);
    rst_n = 1'b1;
    cycle();
    d_req = 1'b0; i_req = 1'b0;
    cycle();
    i_req = 1'b1; i_addr = 10'd5;
    cycle();
    i_req = 1'b0;
    cycle();
    chk("fetch5_data", i_rdata, 32'h2842000A);
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'd100; d_wdata = 32'hDEADBEEF;
    cycle();
    d_we = 1'b0;
    cycle();
    d_req = 1'b0;
    cycle();
    chk("load100_data", d_rdata, 32'hDEADBEEF);
    i_req = 1'b1; i_addr = 10'd7; d_req = 1'b1; d_we = 1'b0;
    for (int k = 0; k < 6; k++) begin
      d_addr = 10'(10 + k);
      cycle();
    end
    d_req = 1'b0;
    cycle();
    i_req = 1'b0;
    cycle();
    i_req = 1'b1; i_addr = 10'd5;
    cycle();
    rst_n = 1'b0; i_req = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("rst_mid_rvalid", 32'(i_rvalid), 32'd0);
    chk("rst_mid_rdata", i_rdata, 32'd0);
    for (int c = 0; c < 500; c++) begin
      if (!i_req || lw_i) begin
        i_req  = $urandom_range(0, 3) != 0;
        i_addr = 10'($urandom_range(0, 31));
      end
      if (!d_req || lw_d) begin
        d_req   = $urandom_range(0, 2) != 0;
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = 10'($urandom_range(0, 31));
        d_wdata = $urandom;
      end
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
